wb_arbiter: RTL and testbench

- Writeback arbiter in front of the dual-write-port register file.
- Accepts register writes from NSRC execution units (ALU0, ALU1, LSU, MUL) over valid/ready handshakes.
- Issues up to two writes per cycle onto the register file's write port 1 and write port 2.
- Never drives both ports to the same register in the same cycle, because a same-address dual write corrupts the XOR-banked storage.

---
 rtl/wb_arbiter_pkg.sv | 20 ++
 rtl/wb_arbiter_rr_pick.sv | 51 +++++
 rtl/wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_wb_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_pkg                                                       |
// | Description : Shared constants for the writeback arbiter: default source   |
// |               count, data width, register address width, statistics       |
// |               counter width, and the hard-wired zero register index.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package wb_pkg;

  localparam int DEF_NSRC  = 4;
  localparam int DEF_XLEN  = 32;
  localparam int DEF_AW    = 5;
  localparam int DEF_CNT_W = 16;

  // Writes to this register index are architecturally discarded.
  localparam int REG_ZERO  = 0;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_pick                                                      |
// | Description : Find-first-set starting at a rotating pointer. Scans req in  |
// |               order ptr, ptr+1, ... mod N and reports the first set bit.   |
// | Ports       : req          in  N   request vector                          |
// |               ptr          in  PW  scan start index (0..N-1)               |
// |               grant_onehot out N   one-hot winner (0 when none)            |
// |               grant_idx    out PW  binary winner index (0 when none)       |
// |               found        out 1   at least one request present            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant_onehot,
  output logic [PW-1:0] grant_idx,
  output logic          found
);

  // One extra bit so ptr + k cannot overflow before the modulo fold.
  localparam logic [PW:0] C_N = (PW+1)'(N);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_j;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    w_sum     = '0;
    w_j       = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, ptr} + (PW+1)'(k);
      if (w_sum >= C_N) begin
        w_sum = w_sum - C_N;
      end
      w_j = w_sum[PW-1:0];
      if (!found && req[w_j]) begin
        found     = 1'b1;
        grant_idx = w_j;
      end
    end
  end

  assign grant_onehot = found ? (N'(1) << grant_idx) : '0;

endmodule : rr_pick
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_arbiter                                                   |
// | Description : Writeback arbiter for a dual-write-port register file.       |
// |               Grants up to two source writes per cycle, round-robin, and   |
// |               never issues the same destination register on both ports.   |
// | Ports       : clk, rst_n            clock, async active-low reset          |
// |               src_valid/src_ready   per-source handshake (ready is comb)   |
// |               src_rd/src_data       packed per-source rd and data          |
// |               we1/w_addr1/w_data1   registered write port 1                |
// |               we2/w_addr2/w_data2   registered write port 2                |
// |               conflict_cnt          saturating same-rd deferral counter    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wb_arbiter #(
  parameter int NSRC  = wb_pkg::DEF_NSRC,
  parameter int XLEN  = wb_pkg::DEF_XLEN,
  parameter int AW    = wb_pkg::DEF_AW,
  parameter int CNT_W = wb_pkg::DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC-1:0]      src_valid,
  output logic [NSRC-1:0]      src_ready,
  input  logic [NSRC*AW-1:0]   src_rd,
  input  logic [NSRC*XLEN-1:0] src_data,
  output logic                 we1,
  output logic [AW-1:0]        w_addr1,
  output logic [XLEN-1:0]      w_data1,
  output logic                 we2,
  output logic [AW-1:0]        w_addr2,
  output logic [XLEN-1:0]      w_data2,
  output logic [CNT_W-1:0]     conflict_cnt
);

  import wb_pkg::*;

  localparam int PW = $clog2(NSRC);
  localparam logic [PW-1:0] C_LAST = PW'(NSRC - 1);
  localparam logic [AW-1:0] C_ZERO = AW'(REG_ZERO);

  logic [AW-1:0]   w_rd   [NSRC];
  logic [XLEN-1:0] w_data [NSRC];
  logic [NSRC-1:0] w_zero;      // rd == x0: accepted and discarded
  logic [NSRC-1:0] w_req;       // valid and targeting a real register
  logic [NSRC-1:0] w_same;      // requesters sharing P1's rd (P1 included)
  logic [NSRC-1:0] w_req2;
  logic [NSRC-1:0] w_gnt1;
  logic [NSRC-1:0] w_gnt2;
  logic [PW-1:0]   w_idx1;
  logic [PW-1:0]   w_idx2;
  logic            w_found1;
  logic            w_found2;
  logic [AW-1:0]   w_p1_rd;
  logic            w_defer;

  logic [PW-1:0]   r_rr_ptr;
  logic            r_we1;
  logic [AW-1:0]   r_addr1;
  logic [XLEN-1:0] r_data1;
  logic            r_we2;
  logic [AW-1:0]   r_addr2;
  logic [XLEN-1:0] r_data2;
  logic [CNT_W-1:0] r_cnt;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    return (idx == C_LAST) ? '0 : idx + 1'b1;
  endfunction

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign w_rd[i]   = src_rd[i*AW +: AW];
    assign w_data[i] = src_data[i*XLEN +: XLEN];
    assign w_zero[i] = (w_rd[i] == C_ZERO);
    assign w_req[i]  = src_valid[i] && !w_zero[i];
    assign w_same[i] = w_found1 && w_req[i] && (w_rd[i] == w_p1_rd);
  end

  rr_pick #(.N(NSRC), .PW(PW)) u_pick1 (
    .req          (w_req),
    .ptr          (r_rr_ptr),
    .grant_onehot (w_gnt1),
    .grant_idx    (w_idx1),
    .found        (w_found1)
  );

  assign w_p1_rd = w_rd[w_idx1];

  // Scanning from the same pointer with P1 and its rd-twins removed yields
  // the next eligible source after P1, since nothing before P1 was requesting.
  assign w_req2 = w_req & ~w_same;

  rr_pick #(.N(NSRC), .PW(PW)) u_pick2 (
    .req          (w_req2),
    .ptr          (r_rr_ptr),
    .grant_onehot (w_gnt2),
    .grant_idx    (w_idx2),
    .found        (w_found2)
  );

  assign w_defer   = |(w_same & ~w_gnt1);
  assign src_ready = rst_n ? (w_gnt1 | w_gnt2 | (src_valid & w_zero)) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_we1    <= 1'b0;
      r_addr1  <= '0;
      r_data1  <= '0;
      r_we2    <= 1'b0;
      r_addr2  <= '0;
      r_data2  <= '0;
      r_cnt    <= '0;
    end else begin
      r_we1 <= w_found1;
      if (w_found1) begin
        r_addr1 <= w_p1_rd;
        r_data1 <= w_data[w_idx1];
      end
      r_we2 <= w_found2;
      if (w_found2) begin
        r_addr2 <= w_rd[w_idx2];
        r_data2 <= w_data[w_idx2];
      end
      if (w_found2) begin
        r_rr_ptr <= next_idx(w_idx2);
      end else if (w_found1) begin
        r_rr_ptr <= next_idx(w_idx1);
      end
      if (w_defer && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign we1          = r_we1;
  assign w_addr1      = r_addr1;
  assign w_data1      = r_data1;
  assign we2          = r_we2;
  assign w_addr2      = r_addr2;
  assign w_data2      = r_data2;
  assign conflict_cnt = r_cnt;

endmodule : wb_arbiter
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wb_arbiter                                                |
// | Description : Directed self-checking bench for wb_arbiter with hand-       |
// |               computed expected values.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_wb_arbiter;

  localparam int NSRC  = 4;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 16;

  logic                 clk;
  logic                 rst_n;
  logic [NSRC-1:0]      src_valid;
  logic [NSRC-1:0]      src_ready;
  logic [NSRC*AW-1:0]   src_rd;
  logic [NSRC*XLEN-1:0] src_data;
  logic                 we1;
  logic [AW-1:0]        w_addr1;
  logic [XLEN-1:0]      w_data1;
  logic                 we2;
  logic [AW-1:0]        w_addr2;
  logic [XLEN-1:0]      w_data2;
  logic [CNT_W-1:0]     conflict_cnt;

  int total = 0;
  int bad   = 0;

  wb_arbiter #(.NSRC(NSRC), .XLEN(XLEN), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_rd       (src_rd),
    .src_data     (src_data),
    .we1          (we1),
    .w_addr1      (w_addr1),
    .w_data1      (w_data1),
    .we2          (we2),
    .w_addr2      (w_addr2),
    .w_data2      (w_data2),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic v, input logic [AW-1:0] rd,
                         input logic [XLEN-1:0] d);
    src_valid[i]           = v;
    src_rd[i*AW +: AW]     = rd;
    src_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic clear_all();
    src_valid = '0;
    src_rd    = '0;
    src_data  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [NSRC-1:0] fair_rdy [4];
  logic [AW-1:0]   fair_a1  [4];
  logic [AW-1:0]   fair_a2  [4];

  initial begin
    // ---------------- power-on reset with all sources requesting
    rst_n = 1'b0;
    clear_all();
    for (int i = 0; i < NSRC; i++) set_src(i, 1'b1, AW'(i + 1), XLEN'(32'h50 + i));
    #1;
    check("rst_ready", 64'(src_ready), 64'h0);
    check("rst_we1", 64'(we1), 64'h0);
    check("rst_we2", 64'(we2), 64'h0);
    check("rst_cnt", 64'(conflict_cnt), 64'h0);
    tick();
    tick();
    check("rst_hold_we1", 64'(we1), 64'h0);
    check("rst_hold_addr1", 64'(w_addr1), 64'h0);
    clear_all();
    rst_n = 1'b1;

    // ---------------- single write, ptr 0 -> 1
    set_src(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    check("single_ready", 64'(src_ready), 64'b0001);
    tick();
    clear_all();
    check("single_we1", 64'(we1), 64'h1);
    check("single_addr1", 64'(w_addr1), 64'd5);
    check("single_data1", 64'(w_data1), 64'hDEADBEEF);
    check("single_we2", 64'(we2), 64'h0);

    // ---------------- dual write, ptr 1 -> 3
    set_src(1, 1'b1, 5'd3, 32'h11);
    set_src(2, 1'b1, 5'd7, 32'h22);
    #1;
    check("dual_ready", 64'(src_ready), 64'b0110);
    tick();
    clear_all();
    check("dual_we1", 64'(we1), 64'h1);
    check("dual_addr1", 64'(w_addr1), 64'd3);
    check("dual_data1", 64'(w_data1), 64'h11);
    check("dual_we2", 64'(we2), 64'h1);
    check("dual_addr2", 64'(w_addr2), 64'd7);
    check("dual_data2", 64'(w_data2), 64'h22);

    // ---------------- idle: enables drop, addresses hold
    tick();
    check("idle_we1", 64'(we1), 64'h0);
    check("idle_we2", 64'(we2), 64'h0);
    check("idle_addr1_hold", 64'(w_addr1), 64'd3);
    check("idle_data2_hold", 64'(w_data2), 64'h22);

    // ---------------- ptr is 3: src3 wins port 1 over src0, ptr -> 1
    set_src(0, 1'b1, 5'd10, 32'hA0);
    set_src(3, 1'b1, 5'd11, 32'hB0);
    #1;
    check("rr3_ready", 64'(src_ready), 64'b1001);
    tick();
    clear_all();
    check("rr3_addr1", 64'(w_addr1), 64'd11);
    check("rr3_data1", 64'(w_data1), 64'hB0);
    check("rr3_addr2", 64'(w_addr2), 64'd10);
    check("rr3_data2", 64'(w_data2), 64'hA0);

    // ---------------- collision at ptr 1: src2 deferred, ptr -> 2
    set_src(1, 1'b1, 5'd12, 32'h1);
    set_src(2, 1'b1, 5'd12, 32'h2);
    #1;
    check("pcol_ready", 64'(src_ready), 64'b0010);
    tick();
    clear_all();
    check("pcol_addr1", 64'(w_addr1), 64'd12);
    check("pcol_data1", 64'(w_data1), 64'h1);
    check("pcol_we2", 64'(we2), 64'h0);
    check("pcol_cnt", 64'(conflict_cnt), 64'd1);
    tick();

    // ---------------- mid-stream reset with all four valid
    for (int i = 0; i < NSRC; i++) set_src(i, 1'b1, AW'(i + 1), XLEN'(32'h200 + i));
    #1;
    check("pre_rst_ready", 64'(src_ready), 64'b1100);
    tick();
    check("pre_rst_we1", 64'(we1), 64'h1);
    check("pre_rst_addr2", 64'(w_addr2), 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(src_ready), 64'h0);
    check("mid_rst_we1", 64'(we1), 64'h0);
    check("mid_rst_we2", 64'(we2), 64'h0);
    check("mid_rst_addr1", 64'(w_addr1), 64'h0);
    check("mid_rst_data2", 64'(w_data2), 64'h0);
    check("mid_rst_cnt", 64'(conflict_cnt), 64'h0);
    tick();
    clear_all();
    rst_n = 1'b1;

    // ---------------- collision at ptr 0: src0 first, then src1
    set_src(0, 1'b1, 5'd9, 32'hA);
    set_src(1, 1'b1, 5'd9, 32'hB);
    #1;
    check("col1_ready", 64'(src_ready), 64'b0001);
    tick();
    set_src(0, 1'b0, 5'd0, 32'h0);
    check("col1_addr1", 64'(w_addr1), 64'd9);
    check("col1_data1", 64'(w_data1), 64'hA);
    check("col1_we2", 64'(we2), 64'h0);
    check("col1_cnt", 64'(conflict_cnt), 64'd1);
    #1;
    check("col2_ready", 64'(src_ready), 64'b0010);
    tick();
    clear_all();
    check("col2_addr1", 64'(w_addr1), 64'd9);
    check("col2_data1", 64'(w_data1), 64'hB);
    check("col2_cnt", 64'(conflict_cnt), 64'd1);

    // ---------------- fairness from ptr 2, distinct rd 1..4
    fair_rdy[0] = 4'b1100; fair_a1[0] = 5'd3; fair_a2[0] = 5'd4;
    fair_rdy[1] = 4'b0011; fair_a1[1] = 5'd1; fair_a2[1] = 5'd2;
    fair_rdy[2] = 4'b1100; fair_a1[2] = 5'd3; fair_a2[2] = 5'd4;
    fair_rdy[3] = 4'b0011; fair_a1[3] = 5'd1; fair_a2[3] = 5'd2;
    for (int i = 0; i < NSRC; i++) set_src(i, 1'b1, AW'(i + 1), XLEN'(32'h100 + i));
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("fair%0d_ready", c), 64'(src_ready), 64'(fair_rdy[c]));
      tick();
      check($sformatf("fair%0d_addr1", c), 64'(w_addr1), 64'(fair_a1[c]));
      check($sformatf("fair%0d_addr2", c), 64'(w_addr2), 64'(fair_a2[c]));
      check($sformatf("fair%0d_we2", c), 64'(we2), 64'h1);
    end
    clear_all();

    // ---------------- x0 drop at ptr 2: src3 -> port1, ptr -> 0
    set_src(0, 1'b1, 5'd0, 32'h99);
    set_src(3, 1'b1, 5'd4, 32'h44);
    #1;
    check("x0_ready", 64'(src_ready), 64'b1001);
    tick();
    set_src(3, 1'b0, 5'd0, 32'h0);
    check("x0_we1", 64'(we1), 64'h1);
    check("x0_addr1", 64'(w_addr1), 64'd4);
    check("x0_data1", 64'(w_data1), 64'h44);
    check("x0_we2", 64'(we2), 64'h0);
    check("x0_cnt", 64'(conflict_cnt), 64'd1);
    #1;
    check("x0only_ready", 64'(src_ready), 64'b0001);
    tick();
    clear_all();
    check("x0only_we1", 64'(we1), 64'h0);
    check("x0only_we2", 64'(we2), 64'h0);
    // x0 must not have moved ptr off 0: src0 beats src3 for port 1
    set_src(0, 1'b1, 5'd6, 32'h66);
    set_src(3, 1'b1, 5'd8, 32'h88);
    tick();
    clear_all();
    check("x0ptr_addr1", 64'(w_addr1), 64'd6);
    check("x0ptr_addr2", 64'(w_addr2), 64'd8);

    // ---------------- saturation: one deferral every cycle, counter starts at 1
    set_src(0, 1'b1, 5'd9, 32'hC0);
    set_src(1, 1'b1, 5'd9, 32'hC1);
    repeat (65533) tick();
    check("sat_fffe", 64'(conflict_cnt), 64'hFFFE);
    tick();
    check("sat_ffff", 64'(conflict_cnt), 64'hFFFF);
    repeat (3) tick();
    check("sat_hold", 64'(conflict_cnt), 64'hFFFF);
    clear_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_wb_arbiter
`default_nettype wire
